// File: rtl/instr_fetch.sv
// instr_fetch: PC-to-decode fetch controller with a req/ack memory port,
// valid/ready decode handshake, retire counter and timeout trap.
module instr_fetch #(
  parameter int BITS    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [BITS-1:0] pc_addr,
  output logic [BITS-1:0] mem_addr,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic [BITS-1:0] mem_rdata,
  output logic [BITS-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [BITS-7:0] jmp_addr,
  output logic            load_instr,
  input  logic            halt,
  output logic            fetch_err,
  output logic [BITS-1:0] instr_count
);

  localparam int TW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT - 1);
  localparam bit T_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VALID,
    S_ERR
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          capture;

  assign mem_addr   = pc_addr;
  assign jmp_addr   = instr[BITS-7:0];
  assign load_instr = instr_valid && instr_ready;
  assign capture    = (state == S_REQ) && mem_ack;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      instr <= '0;
    end else if (capture) begin
      instr <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      instr_count <= '0;
    end else if (load_instr) begin
      instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    fetch_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!halt) state_nxt = S_REQ;
      end
      S_REQ: begin
        mem_req = 1'b1;
        // an ack in the expiry cycle still wins
        if (mem_ack) begin
          state_nxt = S_VALID;
          timer_nxt = '0;
        end else if (T_EN && timer == T_LAST) begin
          state_nxt = S_ERR;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_VALID: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_nxt = halt ? S_IDLE : S_REQ;
        end
      end
      S_ERR: begin
        fetch_err = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: randomized memory/decode stimulus
// checked against a transaction-level fetch model.
module tb_instr_fetch;
  localparam int BITS = 32;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst_ = 1'b0;
  logic [BITS-1:0] pc_addr = '0;
  logic [BITS-1:0] mem_addr;
  logic            mem_req;
  logic            mem_ack = 1'b0;
  logic [BITS-1:0] mem_rdata = '0;
  logic [BITS-1:0] instr;
  logic            instr_valid;
  logic            instr_ready = 1'b0;
  logic [BITS-7:0] jmp_addr;
  logic            load_instr;
  logic            halt = 1'b0;
  logic            fetch_err;
  logic [BITS-1:0] instr_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.BITS(BITS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_(rst_), .pc_addr(pc_addr),
    .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jmp_addr(jmp_addr),
    .load_instr(load_instr), .halt(halt),
    .fetch_err(fetch_err), .instr_count(instr_count)
  );

  // model: fetch outstanding, word held, trapped
  bit              m_req, m_held, m_err;
  logic [BITS-1:0] m_instr, m_count, m_pc;
  int              m_waited;
  int              r_cnt, r_target;
  int              min_wait, max_wait;
  bit              never_ack, noise;
  int              data_mode;
  logic [BITS-1:0] fixed_data;

  function automatic logic [BITS-1:0] mem_word(
    input logic [BITS-1:0] a);
    case (data_mode)
      0:       return 32'h1000_0000 + a;
      1:       return $urandom;
      default: return fixed_data;
    endcase
  endfunction

  task automatic model_reset();
    m_req = 0; m_held = 0; m_err = 0;
    m_instr = '0; m_count = '0; m_pc = '0;
    m_waited = 0; r_cnt = 0;
    r_target = $urandom_range(min_wait, max_wait);
  endtask

  task automatic model_step();
    if (m_err) begin
    end else if (m_held) begin
      if (instr_ready) begin
        m_count++; m_pc++;
        m_held = 0; m_req = !halt;
      end
    end else if (m_req) begin
      if (mem_ack) begin
        m_held = 1; m_req = 0;
        m_instr = mem_rdata;
        m_waited = 0; r_cnt = 0;
        r_target = $urandom_range(min_wait, max_wait);
      end else begin
        m_waited++; r_cnt++;
        if (m_waited == TO) begin
          m_err = 1; m_req = 0;
        end
      end
    end else begin
      m_req = !halt;
    end
  endtask

  task automatic drive(input bit rdy, input bit hlt);
    instr_ready = rdy;
    halt = hlt;
    if (m_req) begin
      mem_ack = !never_ack && (r_cnt >= r_target);
      mem_rdata = mem_word(pc_addr);
    end else begin
      mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_) model_reset();
    else model_step();
    #1;
    pc_addr = m_pc;
  endtask

  task automatic apply_reset();
    rst_ = 1'b0;
    model_reset();
    pc_addr = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    min_wait = 0; max_wait = 0;
    never_ack = 0; noise = 1; data_mode = 1;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      pc_addr = $urandom;
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      instr_ready = 1'($urandom_range(0, 1));
      halt = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if ({mem_req, instr_valid, load_instr, fetch_err} !== 4'b0 ||
          instr !== '0 || jmp_addr !== '0 || instr_count !== '0) begin
        bad++;
        $display("FAIL rst_outs got=%b/%h/%h exp=0",
          {mem_req, instr_valid, load_instr, fetch_err},
          instr, instr_count);
      end
      total++;
      if (mem_addr !== pc_addr) begin
        bad++;
        $display("FAIL rst_addr got=%h exp=%h", mem_addr, pc_addr);
      end
      @(posedge clk);
      #1;
    end
    pc_addr = '0;
    rst_ = 1'b1;
    drive(1'b1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++;
      if (mem_req !== 1'b0 || m_req) begin
        bad++;
        $display("FAIL rst_halt got=%b exp=0 c=%0d", mem_req, c);
      end
      tick();
      drive(1'b1, 1'b1);
    end
  endtask

  task automatic test_zero_wait();
    data_mode = 0; min_wait = 0; max_wait = 0;
    never_ack = 0; noise = 1;
    apply_reset();
    rst_ = 1'b1;
    drive(1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if ({mem_req, instr_valid, load_instr, fetch_err} !==
          {m_req, m_held, m_held && instr_ready, m_err} ||
          instr !== m_instr || instr_count !== m_count) begin
        bad++;
        $display("FAIL zw_model c=%0d got=%b/%h/%h exp=%b/%h/%h", c,
          {mem_req, instr_valid, load_instr, fetch_err}, instr,
          instr_count, {m_req, m_held, m_held && instr_ready, m_err},
          m_instr, m_count);
      end
      if (c == 1) begin
        total++;
        if (mem_req !== 1'b1 || mem_addr !== '0) begin
          bad++;
          $display("FAIL zw_first got=%b/%h exp=1/0", mem_req, mem_addr);
        end
      end
      if (c == 2 || c == 4 || c == 6) begin
        total++;
        if (instr !== 32'h1000_0000 + (c / 2 - 1) ||
            load_instr !== 1'b1) begin
          bad++;
          $display("FAIL zw_instr c=%0d got=%h/%b exp=%h/1", c, instr,
            load_instr, 32'h1000_0000 + (c / 2 - 1));
        end
      end
      if (c == 7) begin
        total++;
        if (instr_count !== 32'd3) begin
          bad++;
          $display("FAIL zw_count got=%0d exp=3", instr_count);
        end
      end
      tick();
      drive(1'b1, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    int vcnt, reqrun, acc;
    bit prev;
    data_mode = 1; min_wait = 3; max_wait = 3;
    never_ack = 0; noise = 1;
    apply_reset();
    rst_ = 1'b1;
    vcnt = 0; reqrun = 0; acc = 0;
    drive(1'b0, 1'b0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      total++;
      if ({mem_req, instr_valid, load_instr, fetch_err} !==
          {m_req, m_held, m_held && instr_ready, m_err} ||
          instr !== m_instr || instr_count !== m_count ||
          mem_addr !== m_pc) begin
        bad++;
        $display("FAIL bp_model c=%0d got=%b/%h/%h exp=%b/%h/%h", c,
          {mem_req, instr_valid, load_instr, fetch_err}, instr,
          instr_count, {m_req, m_held, m_held && instr_ready, m_err},
          m_instr, m_count);
      end
      if (mem_req === 1'b1) reqrun++;
      if (instr_valid === 1'b1 && vcnt == 0) begin
        total++;
        if (reqrun !== 4) begin
          bad++;
          $display("FAIL bp_req_hold got=%0d exp=4", reqrun);
        end
        reqrun = 0;
      end
      if (load_instr === 1'b1) begin
        acc++;
        total++;
        if (vcnt !== 4) begin
          bad++;
          $display("FAIL bp_load got=%0d exp=4", vcnt);
        end
      end
      prev = m_held;
      tick();
      vcnt = (m_held && prev) ? vcnt + 1 : 0;
      drive(m_held && vcnt >= 4, 1'b0);
    end
    total++;
    if (acc !== 4 || instr_count !== 32'd4) begin
      bad++;
      $display("FAIL bp_accepts got=%0d/%0d exp=4", acc, instr_count);
    end
  endtask

  task automatic test_back_to_back();
    data_mode = 1; min_wait = 0; max_wait = 3;
    never_ack = 0; noise = 1;
    apply_reset();
    rst_ = 1'b1;
    drive(1'b1, 1'b0);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      total++;
      if ({mem_req, instr_valid, load_instr, fetch_err} !==
          {m_req, m_held, m_held && instr_ready, m_err} ||
          instr !== m_instr || jmp_addr !== m_instr[BITS-7:0] ||
          instr_count !== m_count || mem_addr !== m_pc) begin
        bad++;
        $display("FAIL b2b_model c=%0d got=%b/%h/%h exp=%b/%h/%h", c,
          {mem_req, instr_valid, load_instr, fetch_err}, instr,
          instr_count, {m_req, m_held, m_held && instr_ready, m_err},
          m_instr, m_count);
      end
      tick();
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
    end
  endtask

  task automatic test_jump();
    data_mode = 2; fixed_data = 32'h0BAD_CAFE;
    min_wait = 0; max_wait = 0; never_ack = 0; noise = 0;
    apply_reset();
    rst_ = 1'b1;
    drive(1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 2) begin
        total++;
        if (instr_valid !== 1'b1 || jmp_addr !== 26'h3AD_CAFE) begin
          bad++;
          $display("FAIL jmp got=%b/%h exp=1/3adcafe",
            instr_valid, jmp_addr);
        end
      end
      tick();
      drive(1'b0, 1'b0);
    end
  endtask

  task automatic test_halt();
    data_mode = 0; min_wait = 2; max_wait = 2;
    never_ack = 0; noise = 1;
    apply_reset();
    rst_ = 1'b1;
    drive(1'b1, 1'b0);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      total++;
      if ({mem_req, instr_valid, load_instr, fetch_err} !==
          {m_req, m_held, m_held && instr_ready, m_err} ||
          instr !== m_instr || instr_count !== m_count) begin
        bad++;
        $display("FAIL halt_model c=%0d got=%b exp=%b", c,
          {mem_req, instr_valid, load_instr, fetch_err},
          {m_req, m_held, m_held && instr_ready, m_err});
      end
      if (c == 4) begin
        total++;
        if (instr_valid !== 1'b1 || instr !== 32'h1000_0000) begin
          bad++;
          $display("FAIL halt_done got=%b/%h exp=1/10000000",
            instr_valid, instr);
        end
      end
      if (c >= 5 && c <= 10) begin
        total++;
        if (mem_req !== 1'b0) begin
          bad++;
          $display("FAIL halt_idle c=%0d got=%b exp=0", c, mem_req);
        end
      end
      if (c == 11) begin
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'd1) begin
          bad++;
          $display("FAIL halt_resume got=%b/%h exp=1/1",
            mem_req, mem_addr);
        end
      end
      tick();
      drive(1'b1, c + 1 >= 2 && c + 1 < 10);
    end
  endtask

  task automatic test_timeout();
    int reqs;
    data_mode = 1; min_wait = 0; max_wait = 0;
    never_ack = 1; noise = 1;
    apply_reset();
    rst_ = 1'b1;
    reqs = 0;
    drive(1'b1, 1'b0);
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) reqs++;
      if (c >= 6) begin
        total++;
        if (fetch_err !== 1'b1 || mem_req !== 1'b0 ||
            instr_valid !== 1'b0 || load_instr !== 1'b0) begin
          bad++;
          $display("FAIL to_stuck c=%0d got=%b exp=0001", c,
            {mem_req, instr_valid, load_instr, fetch_err});
        end
      end
      tick();
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    total++;
    if (reqs !== 4) begin
      bad++;
      $display("FAIL to_req_cycles got=%0d exp=4", reqs);
    end
    never_ack = 0; min_wait = 3; max_wait = 3;
    apply_reset();
    rst_ = 1'b1;
    drive(1'b1, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (fetch_err !== 1'b0 ||
          {mem_req, instr_valid} !== {m_req, m_held}) begin
        bad++;
        $display("FAIL to_late_ack c=%0d got=%b exp=%b", c,
          {mem_req, instr_valid, fetch_err}, {m_req, m_held, 1'b0});
      end
      tick();
      drive(1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    data_mode = 1; min_wait = 3; max_wait = 3;
    never_ack = 0; noise = 1;
    apply_reset();
    rst_ = 1'b1;
    drive(1'b1, 1'b0);
    guard = 0;
    while (!(m_req && r_cnt == 2) && guard < 20) begin
      tick();
      drive(1'b1, 1'b0);
      guard++;
    end
    total++;
    if (guard >= 20) begin
      bad++;
      $display("FAIL rm_reach got=%0d exp<20", guard);
    end
    @(negedge clk);
    #2;
    rst_ = 1'b0;
    model_reset();
    #1;
    total++;
    if ({mem_req, instr_valid, load_instr, fetch_err} !== 4'b0 ||
        instr !== '0 || instr_count !== '0) begin
      bad++;
      $display("FAIL rm_async got=%b/%h exp=0",
        {mem_req, instr_valid, load_instr, fetch_err}, instr);
    end
    @(posedge clk);
    #1;
    pc_addr = '0;
    rst_ = 1'b1;
    drive(1'b1, 1'b0);
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL rm_idle got=%b exp=0", mem_req);
    end
    tick();
    drive(1'b1, 1'b0);
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== '0) begin
      bad++;
      $display("FAIL rm_req got=%b/%h exp=1/0", mem_req, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_back_to_back();
    test_jump();
    test_halt();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
